// File: rtl/traffic_light_ctrl_if.sv
// Control inputs and lamp/countdown outputs of the two-road traffic light sequencer.
// The master side drives enable and pedestrian request; the controller is the slave.
interface traffic_light_ctrl_if;
  logic       en;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [2:0] phase;

  modport master (
    output en, ped_req,
    input  ns_light, ew_light, bcd_tens, bcd_ones, phase
  );

  modport slave (
    input  en, ped_req,
    output ns_light, ew_light, bcd_tens, bcd_ones, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Six-phase two-road traffic light sequencer with a per-second BCD countdown
// and pedestrian-request green shortening.
module traffic_light_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 3,
  parameter int CLEAR_T  = 2,
  parameter int PED_T    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  tl
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0] GREEN_BCD  = {4'(GREEN_T / 10),  4'(GREEN_T % 10)};
  localparam logic [7:0] YELLOW_BCD = {4'(YELLOW_T / 10), 4'(YELLOW_T % 10)};
  localparam logic [7:0] CLEAR_BCD  = {4'(CLEAR_T / 10),  4'(CLEAR_T % 10)};
  localparam logic [7:0] PED_BCD    = {4'(PED_T / 10),    4'(PED_T % 10)};

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    S_NSG = 3'd0,
    S_NSY = 3'd1,
    S_AR1 = 3'd2,
    S_EWG = 3'd3,
    S_EWY = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  function automatic state_t next_state(input state_t s);
    case (s)
      S_NSG:   return S_NSY;
      S_NSY:   return S_AR1;
      S_AR1:   return S_EWG;
      S_EWG:   return S_EWY;
      S_EWY:   return S_AR2;
      default: return S_NSG;
    endcase
  endfunction

  function automatic logic [7:0] load_val(input state_t s);
    case (s)
      S_NSG, S_EWG: return GREEN_BCD;
      S_NSY, S_EWY: return YELLOW_BCD;
      default:      return CLEAR_BCD;
    endcase
  endfunction

  // Returns {ns, ew} lamp patterns.
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      S_NSG:   return {LAMP_G, LAMP_R};
      S_NSY:   return {LAMP_Y, LAMP_R};
      S_EWG:   return {LAMP_R, LAMP_G};
      S_EWY:   return {LAMP_R, LAMP_Y};
      default: return {LAMP_R, LAMP_R};
    endcase
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            ped_q, ped_d;
  logic [2:0]      ns_q, ns_d, ew_q, ew_d;
  logic            tick;
  logic            green;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    ns_d    = ns_q;
    ew_d    = ew_q;
    tick    = tl.en && (presc_q == PRESC_MAX);
    green   = (state_q == S_NSG) || (state_q == S_EWG);
    // Requests latch even while frozen; a request in a shortening tick is kept.
    ped_d   = ped_q | (green & tl.ped_req);

    if (tl.en) presc_d = tick ? '0 : presc_q + 1'b1;

    if (tick) begin
      if (cnt_q == 8'h01) begin
        state_d      = next_state(state_q);
        cnt_d        = load_val(state_d);
        {ns_d, ew_d} = lamps(state_d);
        ped_d        = 1'b0;
      end else if (green && ped_q && (cnt_q > PED_BCD)) begin
        // BCD ordering matches numeric ordering, so a plain compare is safe.
        cnt_d = PED_BCD;
        ped_d = tl.ped_req;
      end else begin
        cnt_d = bcd_dec(cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NSG;
      presc_q <= '0;
      cnt_q   <= GREEN_BCD;
      ped_q   <= 1'b0;
      ns_q    <= LAMP_G;
      ew_q    <= LAMP_R;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign tl.phase    = state_q;
  assign tl.ns_light = ns_q;
  assign tl.ew_light = ew_q;
  assign tl.bcd_tens = cnt_q[7:4];
  assign tl.bcd_ones = cnt_q[3:0];

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: checkpoint table over one full cycle,
// plus hand sequences for reset, pedestrian shortening, freeze and lamp safety.
module tb_traffic_light_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_light_ctrl_if tl ();

  traffic_light_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tl    (tl)
  );

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [3:0] t;
    logic [3:0] o;
  } vec_t;

  vec_t tbl [16];

  int errs   = 0;
  int checks = 0;
  int edge_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic chk_state(input string nm, input logic [2:0] ph, input logic [2:0] ns,
                           input logic [2:0] ew, input logic [3:0] t, input logic [3:0] o);
    chk({nm, ".phase"}, 32'(tl.phase),    32'(ph));
    chk({nm, ".ns"},    32'(tl.ns_light), 32'(ns));
    chk({nm, ".ew"},    32'(tl.ew_light), 32'(ew));
    chk({nm, ".tens"},  32'(tl.bcd_tens), 32'(t));
    chk({nm, ".ones"},  32'(tl.bcd_ones), 32'(o));
  endtask

  // Advance to the given number of rising edges since reset release, sample 1ns later.
  task automatic adv_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    tl.en      = 1'b1;
    tl.ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    logic ok;
    tl.en      = 1'b0;
    tl.ped_req = 1'b0;

    tbl[0]  = '{0,   3'd0, G, R, 4'd1, 4'd5};
    tbl[1]  = '{3,   3'd0, G, R, 4'd1, 4'd5};
    tbl[2]  = '{4,   3'd0, G, R, 4'd1, 4'd4};
    tbl[3]  = '{23,  3'd0, G, R, 4'd1, 4'd0};
    tbl[4]  = '{24,  3'd0, G, R, 4'd0, 4'd9};
    tbl[5]  = '{59,  3'd0, G, R, 4'd0, 4'd1};
    tbl[6]  = '{60,  3'd1, Y, R, 4'd0, 4'd3};
    tbl[7]  = '{71,  3'd1, Y, R, 4'd0, 4'd1};
    tbl[8]  = '{72,  3'd2, R, R, 4'd0, 4'd2};
    tbl[9]  = '{79,  3'd2, R, R, 4'd0, 4'd1};
    tbl[10] = '{80,  3'd3, R, G, 4'd1, 4'd5};
    tbl[11] = '{139, 3'd3, R, G, 4'd0, 4'd1};
    tbl[12] = '{140, 3'd4, R, Y, 4'd0, 4'd3};
    tbl[13] = '{152, 3'd5, R, R, 4'd0, 4'd2};
    tbl[14] = '{159, 3'd5, R, R, 4'd0, 4'd1};
    tbl[15] = '{160, 3'd0, G, R, 4'd1, 4'd5};

    // Full default cycle against the checkpoint table.
    do_reset();
    chk_state("rst_release", 3'd0, G, R, 4'd1, 4'd5);
    for (int i = 0; i < 16; i++) begin
      adv_to(tbl[i].cyc);
      chk_state($sformatf("tbl%0d", i), tbl[i].ph, tbl[i].ns, tbl[i].ew, tbl[i].t, tbl[i].o);
    end

    // Asynchronous reset mid-phase, held while en stays high.
    adv_to(170);
    rst_n = 1'b0;
    #1;
    chk_state("rst_async", 3'd0, G, R, 4'd1, 4'd5);
    repeat (7) @(posedge clk);
    #1;
    chk_state("rst_hold", 3'd0, G, R, 4'd1, 4'd5);

    // Pedestrian: pulse at display 12 shortens to 05; yellow pulse ignored; pulse at 04 no effect.
    do_reset();
    adv_to(13);
    chk_state("ped_pre", 3'd0, G, R, 4'd1, 4'd2);
    tl.ped_req = 1'b1;
    adv_to(14);
    tl.ped_req = 1'b0;
    adv_to(15);
    chk_state("ped_hold12", 3'd0, G, R, 4'd1, 4'd2);
    adv_to(16);
    chk_state("ped_short05", 3'd0, G, R, 4'd0, 4'd5);
    adv_to(20);
    chk_state("ped_04", 3'd0, G, R, 4'd0, 4'd4);
    adv_to(35);
    chk_state("ped_01", 3'd0, G, R, 4'd0, 4'd1);
    adv_to(36);
    chk_state("ped_yellow", 3'd1, Y, R, 4'd0, 4'd3);
    adv_to(41);
    tl.ped_req = 1'b1;
    adv_to(42);
    tl.ped_req = 1'b0;
    adv_to(56);
    chk_state("ew_full15", 3'd3, R, G, 4'd1, 4'd5);
    adv_to(60);
    chk_state("ew_14", 3'd3, R, G, 4'd1, 4'd4);
    adv_to(101);
    chk_state("ew_04", 3'd3, R, G, 4'd0, 4'd4);
    tl.ped_req = 1'b1;
    adv_to(102);
    tl.ped_req = 1'b0;
    adv_to(104);
    chk_state("late_ped_03", 3'd3, R, G, 4'd0, 4'd3);
    adv_to(115);
    chk_state("late_ped_01", 3'd3, R, G, 4'd0, 4'd1);
    adv_to(116);
    chk_state("late_ped_yel", 3'd4, R, Y, 4'd0, 4'd3);

    // Freeze for 7 cycles at EW green display 09.
    do_reset();
    adv_to(105);
    chk_state("frz_pre", 3'd3, R, G, 4'd0, 4'd9);
    tl.en = 1'b0;
    adv_to(112);
    chk_state("frz_mid", 3'd3, R, G, 4'd0, 4'd9);
    tl.en = 1'b1;
    adv_to(114);
    chk_state("frz_hold", 3'd3, R, G, 4'd0, 4'd9);
    adv_to(115);
    chk_state("frz_08", 3'd3, R, G, 4'd0, 4'd8);
    adv_to(146);
    chk_state("frz_end01", 3'd3, R, G, 4'd0, 4'd1);
    adv_to(147);
    chk_state("frz_yellow", 3'd4, R, Y, 4'd0, 4'd3);

    // Lamp safety and digit range under random en/ped_req.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      ok = $onehot(tl.ns_light) && $onehot(tl.ew_light) &&
           (tl.ns_light[2] || tl.ew_light[2]) &&
           (tl.bcd_tens <= 4'd9) && (tl.bcd_ones <= 4'd9) && (tl.phase <= 3'd5);
      chk("lamp_safe", 32'(ok), 32'd1);
      tl.en      = ($urandom_range(0, 3) != 0);
      tl.ped_req = ($urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
